// File: rtl/uart_loader_pkg.sv
// Shared types, parity constants and baud divisor helper for the UART program loader.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Clock cycles per oversample tick, clamped so a tick always exists.
  function automatic int tick_divisor(input int clk_freq, input int baud, input int oversample);
    int div;
    div = clk_freq / (baud * oversample);
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: input synchroniser, oversample tick, majority-vote RX FSM.
module uart_rx_core
  import uart_loader_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD        = 115_200,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  input  logic       i_enable,
  output logic [7:0] o_byte,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_start,
  output logic       o_tick,
  output logic       o_line_high,
  output rx_state_e  o_state
);

  localparam int DIV = tick_divisor(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = $clog2(OVERSAMPLE + 1);
  localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] FULL = CW'(OVERSAMPLE);

  rx_state_e     state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_bad_q, par_bad_d;
  logic [1:0]    hist_q, hist_d;
  logic          sync1_q, sync2_q, prev_q;
  logic          tick, fall, maj, at_start_mid, at_bit_mid;

  // Valid/ready note: the core has no backpressure; o_valid, o_frame_err and
  // o_parity_err are single-cycle pulses at the stop-bit centre sample.

  assign tick         = (div_q == DW'(DIV - 1));
  assign fall         = prev_q & ~sync2_q;
  assign maj          = (hist_q[1] & hist_q[0]) | (hist_q[1] & sync2_q) | (hist_q[0] & sync2_q);
  assign cnt_inc      = cnt_q + 1'b1;
  assign at_start_mid = tick && (cnt_inc == MID);
  assign at_bit_mid   = tick && (cnt_inc == FULL);

  always_comb begin
    div_d  = tick ? '0 : div_q + 1'b1;
    hist_d = tick ? {hist_q[0], sync2_q} : hist_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      par_bad_q <= 1'b0;
      hist_q    <= 2'b11;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      par_bad_q <= par_bad_d;
      hist_q    <= hist_d;
      sync1_q   <= i_rx;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = tick ? cnt_inc : cnt_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    par_bad_d = par_bad_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall && i_enable) state_d = START;
      end
      START: begin
        if (at_start_mid) begin
          cnt_d     = '0;
          bit_d     = '0;
          par_bad_d = 1'b0;
          state_d   = maj ? IDLE : DATA;
        end
      end
      DATA: begin
        if (at_bit_mid) begin
          cnt_d   = '0;
          shreg_d = {maj, shreg_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (at_bit_mid) begin
          cnt_d     = '0;
          par_bad_d = (^{shreg_q, maj}) != (PARITY_MODE == PARITY_ODD);
          state_d   = STOP;
        end
      end
      STOP: begin
        if (at_bit_mid) begin
          cnt_d   = '0;
          state_d = maj ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (sync2_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_valid      = 1'b0;
    o_frame_err  = 1'b0;
    o_parity_err = 1'b0;
    o_start      = (state_q == IDLE) && fall && i_enable;
    if (state_q == STOP && at_bit_mid) begin
      if (!maj)           o_frame_err  = 1'b1;
      else if (par_bad_q) o_parity_err = 1'b1;
      else                o_valid      = 1'b1;
    end
  end

  assign o_byte      = shreg_q;
  assign o_tick      = tick;
  assign o_line_high = sync2_q;
  assign o_state     = state_q;

endmodule

// File: rtl/uart_program_loader.sv
// UART instruction loader: packs received bytes into words, writes them to
// consecutive addresses and flags completion after an idle-line timeout.
module uart_program_loader
  import uart_loader_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD        = 115_200,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int INSTR_BYTES = 2,
  parameter int MSB_FIRST   = 1,
  parameter int ADDR_WIDTH  = 8,
  parameter int BASE_ADDR   = 1,
  parameter int IDLE_BITS   = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_rx,
  input  logic                     i_enable,
  output logic                     o_wr_en,
  output logic [ADDR_WIDTH-1:0]    o_wr_addr,
  output logic [8*INSTR_BYTES-1:0] o_wr_data,
  output logic                     o_load_done,
  output logic [ADDR_WIDTH-1:0]    o_max_addr,
  output logic                     o_busy,
  output logic                     o_frame_err,
  output logic                     o_parity_err,
  output logic                     o_overflow
);

  localparam int DW = 8 * INSTR_BYTES;
  localparam int CW = $clog2(INSTR_BYTES + 1);
  localparam int OW = $clog2(OVERSAMPLE + 1);
  localparam int TW = $clog2(IDLE_BITS + 1);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  logic [7:0] rx_byte;
  logic       rx_valid, rx_frame_err, rx_parity_err, rx_start, rx_tick, rx_line_high;
  rx_state_e  rx_state;

  uart_rx_core #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD        (BAUD),
    .OVERSAMPLE  (OVERSAMPLE),
    .PARITY_MODE (PARITY_MODE)
  ) u_rx (
    .clk          (clk),
    .rst          (rst),
    .i_rx         (i_rx),
    .i_enable     (i_enable),
    .o_byte       (rx_byte),
    .o_valid      (rx_valid),
    .o_frame_err  (rx_frame_err),
    .o_parity_err (rx_parity_err),
    .o_start      (rx_start),
    .o_tick       (rx_tick),
    .o_line_high  (rx_line_high),
    .o_state      (rx_state)
  );

  logic [DW-1:0]         word_q, word_d, word_ins;
  logic [CW-1:0]         count_q, count_d, slot;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, max_addr_q, max_addr_d, wr_addr_q, wr_addr_d;
  logic [DW-1:0]         wr_data_q, wr_data_d;
  logic                  wr_en_q, wr_en_d, full_q, full_d, written_q, written_d;
  logic                  done_q, done_d, overflow_q, overflow_d;
  logic                  frame_err_q, frame_err_d, parity_err_q, parity_err_d;
  logic [OW-1:0]         sub_q, sub_d;
  logic [TW-1:0]         idle_q, idle_d;
  logic                  timing;

  // Byte lane for the next byte; MSB_FIRST puts the first byte in the top lane.
  always_comb begin
    slot     = (MSB_FIRST != 0) ? CW'(INSTR_BYTES - 1) - count_q : count_q;
    word_ins = word_q;
    for (int i = 0; i < INSTR_BYTES; i++) begin
      if (slot == CW'(i)) word_ins[8*i +: 8] = rx_byte;
    end
  end

  always_comb begin
    word_d       = word_q;
    count_d      = count_q;
    ptr_d        = ptr_q;
    max_addr_d   = max_addr_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_en_d      = 1'b0;
    full_d       = full_q;
    written_d    = written_q;
    done_d       = done_q;
    overflow_d   = overflow_q;
    frame_err_d  = rx_frame_err;
    parity_err_d = rx_parity_err;
    sub_d        = sub_q;
    idle_d       = idle_q;

    timing = (rx_state == IDLE) && rx_line_high && written_q && !done_q;
    if (!timing) begin
      sub_d  = '0;
      idle_d = '0;
    end else if (rx_tick) begin
      if (sub_q == OW'(OVERSAMPLE - 1)) begin
        sub_d  = '0;
        idle_d = idle_q + 1'b1;
        if (idle_q == TW'(IDLE_BITS - 1)) begin
          done_d  = 1'b1;
          count_d = '0;
          idle_d  = '0;
        end
      end else begin
        sub_d = sub_q + 1'b1;
      end
    end

    if (rx_start && done_q) begin
      done_d    = 1'b0;
      ptr_d     = BASE;
      full_d    = 1'b0;
      written_d = 1'b0;
    end

    if (rx_frame_err || rx_parity_err) begin
      count_d = '0;
    end else if (rx_valid) begin
      word_d = word_ins;
      if (count_q == CW'(INSTR_BYTES - 1)) begin
        count_d   = '0;
        written_d = 1'b1;
        if (full_q) begin
          overflow_d = 1'b1;
        end else begin
          wr_en_d    = 1'b1;
          wr_addr_d  = ptr_q;
          wr_data_d  = word_ins;
          max_addr_d = ptr_q;
          // The top address is written once; the pointer then parks there.
          if (ptr_q == LAST) full_d = 1'b1;
          else               ptr_d  = ptr_q + 1'b1;
        end
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q       <= '0;
      count_q      <= '0;
      ptr_q        <= BASE;
      max_addr_q   <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_en_q      <= 1'b0;
      full_q       <= 1'b0;
      written_q    <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      sub_q        <= '0;
      idle_q       <= '0;
    end else begin
      word_q       <= word_d;
      count_q      <= count_d;
      ptr_q        <= ptr_d;
      max_addr_q   <= max_addr_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
      full_q       <= full_d;
      written_q    <= written_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      sub_q        <= sub_d;
      idle_q       <= idle_d;
    end
  end

  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_load_done  = done_q;
  assign o_max_addr   = max_addr_q;
  assign o_busy       = (rx_state != IDLE) || (count_q != '0);
  assign o_frame_err  = frame_err_q;
  assign o_parity_err = parity_err_q;
  assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench: dut0 is 8N1 with 8-bit addresses, dut1 uses even parity and 2-bit addresses.
`timescale 1ns/1ps
module tb_uart_program_loader;

  localparam int BIT = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx0 = 1'b1;
  logic rx1 = 1'b1;
  logic en  = 1'b1;

  logic        wr_en0, done0, busy0, ferr0, perr0, ovf0;
  logic [7:0]  wr_addr0, max0;
  logic [15:0] wr_data0;
  logic        wr_en1, done1, busy1, ferr1, perr1, ovf1;
  logic [1:0]  wr_addr1, max1;
  logic [15:0] wr_data1;

  always #5 clk = ~clk;

  uart_program_loader #(
    .CLK_FREQ(1_000_000), .BAUD(31_250), .OVERSAMPLE(16), .PARITY_MODE(0),
    .INSTR_BYTES(2), .MSB_FIRST(1), .ADDR_WIDTH(8), .BASE_ADDR(1), .IDLE_BITS(20)
  ) dut0 (
    .clk(clk), .rst(rst), .i_rx(rx0), .i_enable(en),
    .o_wr_en(wr_en0), .o_wr_addr(wr_addr0), .o_wr_data(wr_data0),
    .o_load_done(done0), .o_max_addr(max0), .o_busy(busy0),
    .o_frame_err(ferr0), .o_parity_err(perr0), .o_overflow(ovf0)
  );

  uart_program_loader #(
    .CLK_FREQ(1_000_000), .BAUD(31_250), .OVERSAMPLE(16), .PARITY_MODE(1),
    .INSTR_BYTES(2), .MSB_FIRST(1), .ADDR_WIDTH(2), .BASE_ADDR(1), .IDLE_BITS(20)
  ) dut1 (
    .clk(clk), .rst(rst), .i_rx(rx1), .i_enable(en),
    .o_wr_en(wr_en1), .o_wr_addr(wr_addr1), .o_wr_data(wr_data1),
    .o_load_done(done1), .o_max_addr(max1), .o_busy(busy1),
    .o_frame_err(ferr1), .o_parity_err(perr1), .o_overflow(ovf1)
  );

  int checks = 0;
  int errors = 0;
  int ferr_cnt0 = 0, perr_cnt0 = 0, ferr_cnt1 = 0, perr_cnt1 = 0;
  logic [23:0] exp_q0[$];
  logic [17:0] exp_q1[$];
  logic [23:0] e0;
  logic [17:0] e1;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  addr;
    logic [15:0] data;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (ferr0) ferr_cnt0++;
    if (perr0) perr_cnt0++;
    if (ferr1) ferr_cnt1++;
    if (perr1) perr_cnt1++;
    if (wr_en0) begin
      if (exp_q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0 unexpected write: got addr 0x%0h data 0x%0h, none expected", wr_addr0, wr_data0);
      end else begin
        e0 = exp_q0.pop_front();
        check("dut0 write", {8'h00, wr_addr0, wr_data0}, {8'h00, e0});
      end
    end
    if (wr_en1) begin
      if (exp_q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1 unexpected write: got addr 0x%0h data 0x%0h, none expected", wr_addr1, wr_data1);
      end else begin
        e1 = exp_q1.pop_front();
        check("dut1 write", {14'h0, wr_addr1, wr_data1}, {14'h0, e1});
      end
    end
  end

  task automatic set_rx(input int which, input logic v);
    if (which == 0) rx0 = v;
    else            rx1 = v;
  endtask

  task automatic wait_bits(input int n);
    repeat (n * BIT) @(negedge clk);
  endtask

  // One frame plus one idle bit; dut1 frames carry an even parity bit.
  task automatic send_byte(input int which, input logic [7:0] b,
                           input logic bad_par = 1'b0, input logic bad_stop = 1'b0);
    set_rx(which, 1'b0);
    wait_bits(1);
    for (int i = 0; i < 8; i++) begin
      set_rx(which, b[i]);
      wait_bits(1);
    end
    if (which == 1) begin
      set_rx(which, (^b) ^ bad_par);
      wait_bits(1);
    end
    set_rx(which, !bad_stop);
    wait_bits(1);
    set_rx(which, 1'b1);
    wait_bits(1);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'h41, 8'h00, 8'd1, 16'h4100};
    vecs[1] = '{8'h81, 8'h80, 8'd2, 16'h8180};
    vecs[2] = '{8'hFF, 8'h01, 8'd3, 16'hFF01};
    vecs[3] = '{8'h5A, 8'hA5, 8'd4, 16'h5AA5};

    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("reset wr_en", wr_en0, 0);
    check("reset wr_addr", wr_addr0, 0);
    check("reset wr_data", wr_data0, 0);
    check("reset done", done0, 0);
    check("reset max_addr", max0, 0);
    check("reset busy", busy0, 0);
    check("reset frame_err", ferr0, 0);
    check("reset overflow", ovf0, 0);
    check("reset dut1 max_addr", max1, 0);
    check("reset dut1 parity_err", perr1, 0);
    rst = 1'b0;
    wait_bits(2);

    for (int i = 0; i < 4; i++) begin
      exp_q0.push_back({vecs[i].addr, vecs[i].data});
      send_byte(0, vecs[i].b0);
      check("busy with partial word", busy0, 1);
      send_byte(0, vecs[i].b1);
      check("max_addr after word", max0, vecs[i].addr);
      check("busy after word", busy0, 0);
      check("done during load", done0, 0);
    end

    wait_bits(17);
    check("done before timeout", done0, 0);
    wait_bits(3);
    check("done after timeout", done0, 1);
    check("max_addr at done", max0, 4);

    exp_q0.push_back({8'd1, 16'h4100});
    fork
      send_byte(0, 8'h41);
      begin
        repeat (BIT / 2) @(negedge clk);
        check("done drops at start bit", done0, 0);
        check("max_addr holds on reload", max0, 4);
      end
    join
    send_byte(0, 8'h00);
    check("max_addr after reload", max0, 1);
    wait_bits(20);
    check("done after reload timeout", done0, 1);

    send_byte(0, 8'h41);
    send_byte(0, 8'h00, 1'b0, 1'b1);
    check("frame_err pulse count", ferr_cnt0, 1);
    check("busy after frame error", busy0, 0);
    exp_q0.push_back({8'd1, 16'h1234});
    send_byte(0, 8'h12);
    send_byte(0, 8'h34);
    check("max_addr after frame error", max0, 1);

    set_rx(0, 1'b0); wait_bits(1);
    set_rx(0, 1'b1); wait_bits(1);
    set_rx(0, 1'b0); wait_bits(1);
    set_rx(0, 1'b1); wait_bits(1);
    check("busy mid-frame", busy0, 1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("busy in reset", busy0, 0);
    check("max_addr in reset", max0, 0);
    rst = 1'b0;
    wait_bits(1);
    en = 1'b0;
    send_byte(0, 8'h41);
    check("disabled line ignored", busy0, 0);
    en = 1'b1;
    exp_q0.push_back({8'd1, 16'h4126});
    send_byte(0, 8'h41);
    send_byte(0, 8'h26);
    check("max_addr after reset reload", max0, 1);
    check("no frame error after reset", ferr_cnt0, 1);

    send_byte(1, 8'h41, 1'b1);
    check("parity_err pulse count", perr_cnt1, 1);
    check("busy after parity error", busy1, 0);
    exp_q1.push_back({2'd1, 16'h4100});
    send_byte(1, 8'h41);
    send_byte(1, 8'h00);
    exp_q1.push_back({2'd2, 16'h2233});
    send_byte(1, 8'h22);
    send_byte(1, 8'h33);
    exp_q1.push_back({2'd3, 16'h4455});
    send_byte(1, 8'h44);
    send_byte(1, 8'h55);
    check("overflow before drop", ovf1, 0);
    check("dut1 max_addr at top", max1, 3);
    send_byte(1, 8'h66);
    send_byte(1, 8'h77);
    check("overflow after drop", ovf1, 1);
    check("dut1 max_addr holds", max1, 3);

    repeat (10) @(negedge clk);
    check("dut0 parity_err never", perr_cnt0, 0);
    check("dut1 frame_err never", ferr_cnt1, 0);
    check("dut0 missing writes", exp_q0.size(), 0);
    check("dut1 missing writes", exp_q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
